// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter.
// Size codes match the data_size control field used by the core.
package mem_port_arbiter_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_ACK
  } arb_state_t;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_AUX  = 1'b1
  } port_t;

  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    unique case (1'b1)
      (size == SIZE_BYTE): return 1'b0;
      (size == SIZE_HALF): return lo[0];
      default:             return |lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_align.sv
// Byte-lane steering: enables and replicated write data, plus
// right-aligned, size-masked read data from the same offset.
import mem_port_arbiter_pkg::*;

module mem_lane_align (
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [1:0]  w_off;
  logic [31:0] w_mask;

  // Offset is forced to natural alignment for half/word
  always_comb begin
    w_off   = 2'd0;
    w_mask  = 32'hFFFF_FFFF;
    o_wdata = i_wdata;
    unique case (1'b1)
      (i_size == SIZE_BYTE): begin
        w_off   = i_addr;
        w_mask  = 32'h0000_00FF;
        o_wdata = {4{i_wdata[7:0]}};
      end
      (i_size == SIZE_HALF): begin
        w_off   = {i_addr[1], 1'b0};
        w_mask  = 32'h0000_FFFF;
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        w_off   = 2'd0;
        w_mask  = 32'hFFFF_FFFF;
        o_wdata = i_wdata;
      end
    endcase
    unique case (1'b1)
      (i_size == SIZE_BYTE): o_be = 4'b0001 << w_off;
      (i_size == SIZE_HALF): o_be = 4'b0011 << w_off;
      default:               o_be = 4'b1111;
    endcase
    o_rdata = (i_rdata >> {w_off, 3'b000}) & w_mask;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin core/aux arbiter for the single fixed-latency memory port.
// Define MEM_ARB_MISALIGN_CHECK_EN to fault misaligned accesses with err.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  input  logic [1:0]        core_size,
  output logic              core_ack,
  output logic [31:0]       core_rdata,
  output logic              core_err,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [31:0]       aux_wdata,
  input  logic [1:0]        aux_size,
  output logic              aux_ack,
  output logic [31:0]       aux_rdata,
  output logic              aux_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  arb_state_t        r_state;
  port_t             r_last;
  port_t             r_grant;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [1:0]        r_size;
  logic              r_en;
  logic              r_core_ack;
  logic              r_aux_ack;
  logic              r_err;

  logic              w_any;
  logic              w_pick_aux;
  logic              w_mis;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [31:0]       w_sel_wdata;
  logic [1:0]        w_sel_size;
  logic [3:0]        w_be;
  logic [31:0]       w_wd;
  logic [31:0]       w_rd_al;
  logic [31:0]       w_rd;

  assign w_any      = core_req | aux_req;
  // On a tie the port that did not go last wins
  assign w_pick_aux = aux_req & (~core_req | (r_last == PORT_CORE));

  assign w_sel_we    = w_pick_aux ? aux_we    : core_we;
  assign w_sel_addr  = w_pick_aux ? aux_addr  : core_addr;
  assign w_sel_wdata = w_pick_aux ? aux_wdata : core_wdata;
  assign w_sel_size  = w_pick_aux ? aux_size  : core_size;

`ifdef MEM_ARB_MISALIGN_CHECK_EN
  assign w_mis    = is_misaligned(w_sel_size, w_sel_addr[1:0]);
  assign core_err = r_core_ack & r_err;
  assign aux_err  = r_aux_ack & r_err;
`else
  assign w_mis    = 1'b0;
  assign core_err = 1'b0;
  assign aux_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ARB_IDLE;
      r_last     <= PORT_AUX;
      r_grant    <= PORT_CORE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_size     <= SIZE_BYTE;
      r_en       <= 1'b0;
      r_core_ack <= 1'b0;
      r_aux_ack  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_en       <= 1'b0;
      r_core_ack <= 1'b0;
      r_aux_ack  <= 1'b0;
      unique case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick_aux ? PORT_AUX : PORT_CORE;
            r_we    <= w_sel_we;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
            r_size  <= w_sel_size;
            r_err   <= w_mis;
            if (w_mis) begin
              r_state    <= ARB_ACK;
              r_core_ack <= ~w_pick_aux;
              r_aux_ack  <= w_pick_aux;
            end else begin
              r_state <= ARB_ISSUE;
              r_en    <= 1'b1;
            end
          end
        end
        ARB_ISSUE: begin
          r_cnt <= 4'(LATENCY - 1);
          if (LATENCY == 1) begin
            r_state    <= ARB_ACK;
            r_core_ack <= (r_grant == PORT_CORE);
            r_aux_ack  <= (r_grant == PORT_AUX);
          end else begin
            r_state <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state    <= ARB_ACK;
            r_core_ack <= (r_grant == PORT_CORE);
            r_aux_ack  <= (r_grant == PORT_AUX);
          end
        end
        ARB_ACK: begin
          r_last  <= r_grant;
          r_err   <= 1'b0;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  mem_lane_align u_align (
    .i_size  (r_size),
    .i_addr  (r_addr[1:0]),
    .i_wdata (r_wdata),
    .i_rdata (mem_rdata),
    .o_be    (w_be),
    .o_wdata (w_wd),
    .o_rdata (w_rd_al)
  );

  assign w_rd = (r_we | r_err) ? 32'd0 : w_rd_al;

  assign core_ack   = r_core_ack;
  assign aux_ack    = r_aux_ack;
  assign core_rdata = r_core_ack ? w_rd : 32'd0;
  assign aux_rdata  = r_aux_ack  ? w_rd : 32'd0;

  assign mem_en    = r_en;
  assign mem_we    = r_en & r_we;
  assign mem_addr  = r_en ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be    = r_en ? w_be : 4'd0;
  assign mem_wdata = r_en ? w_wd : 32'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: LATENCY=1 instance for the data paths and arbitration,
// LATENCY=3 instance for reset during WAIT.
module tb_mem_port_arbiter;

  typedef struct {
    bit          p;
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } ack_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          cyc;
  } mem_t;

  logic clk;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_err = 0;

  ack_t qa[$];
  ack_t qb[$];
  mem_t qma[$];
  mem_t qmb[$];
  logic [31:0] mem [bit [31:0]];

  logic        a_rst, a_core_req, a_core_we, a_core_ack, a_core_err;
  logic [31:0] a_core_addr, a_core_wdata, a_core_rdata;
  logic [1:0]  a_core_size;
  logic        a_aux_req, a_aux_we, a_aux_ack, a_aux_err;
  logic [31:0] a_aux_addr, a_aux_wdata, a_aux_rdata;
  logic [1:0]  a_aux_size;
  logic        a_mem_en, a_mem_we;
  logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_be;

  logic        b_rst, b_core_req, b_core_we, b_core_ack, b_core_err;
  logic [31:0] b_core_addr, b_core_wdata, b_core_rdata;
  logic [1:0]  b_core_size;
  logic        b_aux_req, b_aux_we, b_aux_ack, b_aux_err;
  logic [31:0] b_aux_addr, b_aux_wdata, b_aux_rdata;
  logic [1:0]  b_aux_size;
  logic        b_mem_en, b_mem_we;
  logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0]  b_mem_be;

  mem_port_arbiter #(.LATENCY(1), .ADDR_W(32)) u_a (
    .clk(clk), .reset(a_rst),
    .core_req(a_core_req), .core_we(a_core_we), .core_addr(a_core_addr),
    .core_wdata(a_core_wdata), .core_size(a_core_size), .core_ack(a_core_ack),
    .core_rdata(a_core_rdata), .core_err(a_core_err),
    .aux_req(a_aux_req), .aux_we(a_aux_we), .aux_addr(a_aux_addr),
    .aux_wdata(a_aux_wdata), .aux_size(a_aux_size), .aux_ack(a_aux_ack),
    .aux_rdata(a_aux_rdata), .aux_err(a_aux_err),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_be(a_mem_be), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  mem_port_arbiter #(.LATENCY(3), .ADDR_W(32)) u_b (
    .clk(clk), .reset(b_rst),
    .core_req(b_core_req), .core_we(b_core_we), .core_addr(b_core_addr),
    .core_wdata(b_core_wdata), .core_size(b_core_size), .core_ack(b_core_ack),
    .core_rdata(b_core_rdata), .core_err(b_core_err),
    .aux_req(b_aux_req), .aux_we(b_aux_we), .aux_addr(b_aux_addr),
    .aux_wdata(b_aux_wdata), .aux_size(b_aux_size), .aux_ack(b_aux_ack),
    .aux_rdata(b_aux_rdata), .aux_err(b_aux_err),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_be(b_mem_be), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function void chk(string n, logic [31:0] act, logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
               n, act, exp, cyc);
    end
  endfunction

  function void fail(string n);
    n_chk = n_chk + 1;
    n_err = n_err + 1;
    $display("FAIL %s (cycle %0d)", n, cyc);
  endfunction

  // Memory models: capture at negedge, present data LATENCY cycles later
  logic [31:0] pend_a, pend_b;
  logic [31:0] lb [3];

  initial begin
    logic [31:0] t;
    pend_a = 32'h0;
    forever begin
      @(negedge clk);
      if (a_mem_en) begin
        pend_a = rd(a_mem_addr);
        if (a_mem_we) begin
          t = rd(a_mem_addr);
          for (int i = 0; i < 4; i++)
            if (a_mem_be[i]) t[8*i +: 8] = a_mem_wdata[8*i +: 8];
          mem[a_mem_addr] = t;
        end
      end else begin
        pend_a = 32'hBAD0_BAD0;
      end
    end
  end

  initial begin
    a_mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      a_mem_rdata = pend_a;
    end
  end

  initial begin
    pend_b = 32'h0;
    forever begin
      @(negedge clk);
      pend_b = b_mem_en ? rd(b_mem_addr) : 32'hBAD0_BAD0;
    end
  end

  initial begin
    b_mem_rdata = 32'h0;
    lb[0] = 32'h0; lb[1] = 32'h0; lb[2] = 32'h0;
    forever begin
      @(posedge clk);
      lb[2] = lb[1];
      lb[1] = lb[0];
      lb[0] = pend_b;
      b_mem_rdata = lb[2];
    end
  end

  // Monitors
  initial begin
    ack_t ea;
    mem_t em;
    forever begin
      @(negedge clk);
      if (a_core_ack && a_aux_ack) fail("a_both_acks");
      else if (a_core_ack || a_aux_ack) begin
        if (qa.size() == 0) fail("a_unexpected_ack");
        else begin
          ea = qa.pop_front();
          chk("a_ack_port", {31'd0, a_aux_ack}, {31'd0, ea.p});
          chk("a_rdata", a_aux_ack ? a_aux_rdata : a_core_rdata, ea.rdata);
          chk("a_err", {31'd0, a_aux_ack ? a_aux_err : a_core_err},
              {31'd0, ea.err});
          chk("a_ack_cycle", cyc, ea.cyc);
        end
      end
      if (a_mem_en) begin
        if (qma.size() == 0) fail("a_unexpected_mem_en");
        else begin
          em = qma.pop_front();
          chk("a_mem_we", {31'd0, a_mem_we}, {31'd0, em.we});
          chk("a_mem_addr", a_mem_addr, em.addr);
          chk("a_mem_be", {28'd0, a_mem_be}, {28'd0, em.be});
          if (em.we) chk("a_mem_wdata", a_mem_wdata, em.wd);
          chk("a_mem_cycle", cyc, em.cyc);
        end
      end
    end
  end

  initial begin
    ack_t ea;
    mem_t em;
    forever begin
      @(negedge clk);
      if (b_core_ack && b_aux_ack) fail("b_both_acks");
      else if (b_core_ack || b_aux_ack) begin
        if (qb.size() == 0) fail("b_unexpected_ack");
        else begin
          ea = qb.pop_front();
          chk("b_ack_port", {31'd0, b_aux_ack}, {31'd0, ea.p});
          chk("b_rdata", b_aux_ack ? b_aux_rdata : b_core_rdata, ea.rdata);
          chk("b_err", {31'd0, b_aux_ack ? b_aux_err : b_core_err}, 32'd0);
          chk("b_ack_cycle", cyc, ea.cyc);
        end
      end
      if (b_mem_en) begin
        if (qmb.size() == 0) fail("b_unexpected_mem_en");
        else begin
          em = qmb.pop_front();
          chk("b_mem_we", {31'd0, b_mem_we}, 32'd0);
          chk("b_mem_addr", b_mem_addr, em.addr);
          chk("b_mem_be", {28'd0, b_mem_be}, {28'd0, em.be});
          chk("b_mem_wdata", b_mem_wdata, 32'd0);
          chk("b_mem_cycle", cyc, em.cyc);
        end
      end
    end
  end

  task automatic rst_chk_a();
    chk("rst_core_ack", {31'd0, a_core_ack}, 32'd0);
    chk("rst_aux_ack", {31'd0, a_aux_ack}, 32'd0);
    chk("rst_mem_en", {31'd0, a_mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, a_mem_we}, 32'd0);
    chk("rst_mem_be", {28'd0, a_mem_be}, 32'd0);
    chk("rst_rdata", a_core_rdata | a_aux_rdata, 32'd0);
    chk("rst_err", {31'd0, a_core_err | a_aux_err}, 32'd0);
  endtask

  task automatic acc_a(input bit p, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] sz,
                       input bit mx, input logic [3:0] be,
                       input logic [31:0] maddr, input logic [31:0] mwd,
                       input logic [31:0] rdata, input bit err);
    int   c;
    bit   got;
    ack_t ea;
    mem_t em;
    @(posedge clk); #1;
    if (p) begin
      a_aux_req = 1'b1; a_aux_we = we; a_aux_addr = addr;
      a_aux_wdata = wd; a_aux_size = sz;
    end else begin
      a_core_req = 1'b1; a_core_we = we; a_core_addr = addr;
      a_core_wdata = wd; a_core_size = sz;
    end
    c = cyc;
    if (mx) begin
      em.we = we; em.addr = maddr; em.be = be; em.wd = mwd; em.cyc = c + 1;
      qma.push_back(em);
    end
    ea.p = p; ea.rdata = rdata; ea.err = err; ea.cyc = mx ? c + 2 : c + 1;
    qa.push_back(ea);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = p ? a_aux_ack : a_core_ack;
    end
    if (!got) fail("a_ack_timeout");
    @(posedge clk); #1;
    a_core_req = 1'b0;
    a_aux_req  = 1'b0;
  endtask

  task automatic acc_b(input bit p, input logic [31:0] addr,
                       input logic [1:0] sz, input logic [3:0] be,
                       input logic [31:0] rdata);
    int   c;
    bit   got;
    ack_t ea;
    mem_t em;
    @(posedge clk); #1;
    if (p) begin
      b_aux_req = 1'b1; b_aux_addr = addr; b_aux_size = sz;
    end else begin
      b_core_req = 1'b1; b_core_addr = addr; b_core_size = sz;
    end
    c = cyc;
    em.we = 1'b0; em.addr = {addr[31:2], 2'b00}; em.be = be;
    em.wd = 32'd0; em.cyc = c + 1;
    qmb.push_back(em);
    ea.p = p; ea.rdata = rdata; ea.err = 1'b0; ea.cyc = c + 4;
    qb.push_back(ea);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = p ? b_aux_ack : b_core_ack;
    end
    if (!got) fail("b_ack_timeout");
    @(posedge clk); #1;
    b_core_req = 1'b0;
    b_aux_req  = 1'b0;
  endtask

  initial begin
    int   p;
    ack_t ea;
    mem_t em;
    a_rst = 1'b0; b_rst = 1'b0;
    a_core_req = 0; a_core_we = 0; a_core_addr = 0; a_core_wdata = 0;
    a_core_size = 0; a_aux_req = 0; a_aux_we = 0; a_aux_addr = 0;
    a_aux_wdata = 0; a_aux_size = 0;
    b_core_req = 0; b_core_we = 0; b_core_addr = 0; b_core_wdata = 0;
    b_core_size = 0; b_aux_req = 0; b_aux_we = 0; b_aux_addr = 0;
    b_aux_wdata = 0; b_aux_size = 0;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h200] = 32'h11223344;
    mem[32'h300] = 32'h00000000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_chk_a();
    @(posedge clk); #1;
    a_rst = 1'b1;
    b_rst = 1'b1;

    acc_a(0, 0, 32'h100, 32'h0, 2'd2, 1, 4'b1111, 32'h100, 32'h0,
          32'hDEADBEEF, 0);
    acc_a(0, 1, 32'h203, 32'h123456A5, 2'd0, 1, 4'b1000, 32'h200,
          32'hA5A5A5A5, 32'h0, 0);
    mem[32'h100] = 32'h12345678;
    acc_a(0, 0, 32'h102, 32'h0, 2'd1, 1, 4'b1100, 32'h100, 32'h0,
          32'h00001234, 0);
    acc_a(1, 0, 32'h201, 32'h0, 2'd0, 1, 4'b0010, 32'h200, 32'h0,
          32'h00000033, 0);
    acc_a(1, 0, 32'h203, 32'h0, 2'd0, 1, 4'b1000, 32'h200, 32'h0,
          32'h000000A5, 0);
    acc_a(1, 1, 32'h302, 32'h5555BEEF, 2'd1, 1, 4'b1100, 32'h300,
          32'hBEEFBEEF, 32'h0, 0);
    acc_a(0, 0, 32'h100, 32'h0, 2'd3, 1, 4'b1111, 32'h100, 32'h0,
          32'h12345678, 0);
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    acc_a(0, 0, 32'h102, 32'h0, 2'd2, 0, 4'b0000, 32'h0, 32'h0,
          32'h0, 1);
    acc_a(1, 0, 32'h303, 32'h0, 2'd1, 0, 4'b0000, 32'h0, 32'h0,
          32'h0, 1);
`else
    acc_a(0, 0, 32'h102, 32'h0, 2'd2, 1, 4'b1111, 32'h100, 32'h0,
          32'h12345678, 0);
    acc_a(1, 0, 32'h303, 32'h0, 2'd1, 1, 4'b1100, 32'h300, 32'h0,
          32'h0000BEEF, 0);
`endif

    // Both requesters held from reset: grants alternate, core first
    @(posedge clk); #1;
    a_rst = 1'b0;
    a_core_req = 1; a_core_we = 0; a_core_addr = 32'h100; a_core_size = 2;
    a_aux_req  = 1; a_aux_we  = 0; a_aux_addr  = 32'h200; a_aux_size  = 2;
    @(posedge clk);
    @(negedge clk);
    rst_chk_a();
    @(posedge clk); #1;
    a_rst = 1'b1;
    p = cyc;
    for (int k = 0; k < 4; k++) begin
      em.we = 1'b0; em.be = 4'b1111; em.wd = 32'h0; em.cyc = p + 1 + 3 * k;
      em.addr = (k % 2 == 1) ? 32'h200 : 32'h100;
      qma.push_back(em);
      ea.p = (k % 2 == 1); ea.err = 1'b0; ea.cyc = p + 2 + 3 * k;
      ea.rdata = (k % 2 == 1) ? 32'hA5223344 : 32'h12345678;
      qa.push_back(ea);
    end
    for (int i = 0; i < 40 && cyc < p + 11; i++) @(negedge clk);
    @(posedge clk); #1;
    a_core_req = 1'b0;
    a_aux_req  = 1'b0;

    // LATENCY=3: reset while in WAIT abandons the access
    @(posedge clk); #1;
    b_aux_req = 1'b1; b_aux_we = 1'b0; b_aux_addr = 32'h100;
    b_aux_size = 2'd2;
    p = cyc;
    em.we = 1'b0; em.addr = 32'h100; em.be = 4'b1111; em.wd = 32'h0;
    em.cyc = p + 1;
    qmb.push_back(em);
    @(posedge clk);
    @(posedge clk); #1;
    b_rst = 1'b0;
    b_aux_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("b_rst_aux_ack", {31'd0, b_aux_ack}, 32'd0);
    chk("b_rst_mem_en", {31'd0, b_mem_en}, 32'd0);
    @(posedge clk); #1;
    b_rst = 1'b1;
    repeat (8) @(negedge clk);
    acc_b(1, 32'h102, 2'd1, 4'b1100, 32'h00001234);
    acc_b(0, 32'h103, 2'd0, 4'b1000, 32'h00000012);

    repeat (5) @(negedge clk);
    chk("queues_drained", qa.size() + qb.size() + qma.size() + qmb.size(),
        32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single unified memory port between two requesters: the multicycle core (fetch and load/store traffic) and an auxiliary port (program loader/debug).
- Arbitrates with round-robin priority and sequences each access through a fixed-latency memory.
- Generates byte enables and lane-shifted write data from size/address.
- Returns right-aligned read data.
- Sits between the core datapath's address mux and the memory macro; the core FSM stalls until ack.

Parameters:
- LATENCY, 1, memory read latency in cycles from mem_en to valid mem_rdata (legal range 1..15)
- ADDR_W, 32, byte address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- core_req  in  1  core access request; held with stable payload until core_ack
- core_we  in  1  1 = store, 0 = load/fetch
- core_addr  in  ADDR_W  byte address
- core_wdata  in  32  store data, right-aligned
- core_size  in  2  0 = byte, 1 = half, 2 = word (same encoding as the data_size control field)
- core_ack  out  1  one-cycle completion pulse
- core_rdata  out  32  read data, right-aligned and zero-extended; valid only when core_ack
- core_err  out  1  misaligned access flag; valid only when core_ack
- aux_req, aux_we, aux_addr, aux_wdata, aux_size, aux_ack, aux_rdata, aux_err  same as core_* for the auxiliary requester
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  write strobe, qualified by mem_en
- mem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
- mem_be  out  4  byte-lane enables
- mem_wdata  out  32  write data shifted into its lanes
- mem_rdata  in  32  raw memory word, valid LATENCY cycles after mem_en

Behaviour:
- Reset (clk edge with reset = 0):
  - state = IDLE, last_grant = AUX (so core wins the first tie), wait counter = 0.
  - All outputs 0: both acks, mem_en, mem_we, mem_be; rdata and err outputs also 0.
- States:
  - IDLE: sample requests and arbitrate. If exactly one req is high, grant it. If both are high, grant the port not equal to last_grant. Register the granted port's payload and go to ISSUE. With no req, stay in IDLE.
  - ISSUE: drive mem_en = 1 plus mem_we/mem_addr/mem_be/mem_wdata from the registered payload. Load counter = LATENCY-1. Go to ACK if LATENCY = 1, otherwise go to WAIT.
  - WAIT: decrement counter; go to ACK when the counter reaches 1. mem_en = 0.
  - ACK: pulse the granted port's ack; the other port's ack stays 0. rdata = (mem_rdata >> 8*addr[1:0]), masked to size (byte: [7:0], half: [15:0]). Update last_grant and return to IDLE.
- Latency:
  - req high in cycle 0 while IDLE → ack in cycle LATENCY+1.
  - Minimum turnaround is LATENCY+2 cycles per access, because the IDLE cycle is always consumed.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
  - size = 3 is treated as word.
- mem_wdata = wdata replicated per size: byte → {4{b}}, half → {2{h}}.
- Payload is registered at grant; requester changes after grant have no effect on the in-flight access.
- A requester deasserting req mid-transaction is illegal. The arbiter still completes the access and pulses ack.
- Both reqs arriving while busy: the waiting port is served next, via last_grant. A port holding req continuously is starved for at most one access.
- Reset mid-access: the access is abandoned, no ack is issued, and a write already strobed stays committed.
- Read data with mem_we = 1: rdata is 0.

Optional Feature:
- Macro MEM_ARB_MISALIGN_CHECK_EN.
- Defined:
  - Misalignment is half with addr[0] = 1, or word with addr[1:0] ≠ 0.
  - A misaligned access skips ISSUE/WAIT and goes from IDLE to ACK in the next cycle.
  - It produces no mem_en pulse and acks with err = 1 and rdata = 0.
- Undefined:
  - err is tied to 0.
  - Misaligned addresses are truncated to natural alignment (half clears addr[0], word clears addr[1:0]) before lane calculation.

Decomposition:
- Shared constants package/include, alongside the existing control constants:
  - size encodings SIZE_BYTE/HALF/WORD, reusing the existing definitions
  - arbiter state encodings ARB_IDLE/ISSUE/WAIT/ACK
  - port IDs PORT_CORE/PORT_AUX
- One natural sub-module, mem_lane_align: combinational be/wdata generation and rdata extraction from size and addr[1:0]. It is instantiated once for the write path and shared by the read path.

Test Plan:
- LATENCY = 1; core read word at 0x100, mem_rdata = 0xDEADBEEF → mem_en in cycle 1 with mem_addr = 0x100, be = 1111; core_ack in cycle 2 with core_rdata = 0xDEADBEEF.
- Core store byte 0xA5 at 0x203 → mem_be = 1000, mem_wdata = 0xA5A5A5A5, mem_addr = 0x200, mem_we = 1.
- Core load half at 0x102, mem_rdata = 0x12345678 → core_rdata = 0x00001234.
- Both reqs held continuously from reset → grants alternate core, aux, core, aux; each ack spaced LATENCY+2 cycles apart.
- LATENCY = 3, aux read, reset pulled low in the WAIT state → no aux_ack, mem_en stays 0, and the next request after reset is served normally.
- With MEM_ARB_MISALIGN_CHECK_EN: core word load at 0x102 → no mem_en pulse; core_ack in cycle 1 with core_err = 1 and core_rdata = 0.
